dist_ram_dp_clr: RTL and testbench

- Parametrised dual-port distributed RAM: next generation of the 32x1 single-bit dual-port LUT RAM model.
- Generalises width and depth.
- Adds an optional registered read path and a hardware clear sequencer that sweeps every location to INIT_VAL after reset or on request.
- Used as register-file / small-buffer storage in the same library where bulk reinitialisation without a bitstream reload is needed.

---
 rtl/dist_ram_dp_clr_pkg.sv | 29 ++
 rtl/dist_ram_dp_clr_seq.sv | 55 +++++
 rtl/dist_ram_dp_clr.sv | 94 +++++++++
 tb/tb_dist_ram_dp_clr.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/dist_ram_dp_clr_pkg.sv
// Shared definitions for the clearable dual-port distributed RAM family.
`ifndef DIST_RAM_DP_CLR_PKG_SV
`define DIST_RAM_DP_CLR_PKG_SV

// Elaboration-time parameter check: a bad parameter set produces an
// elaboration error inside a named generate block.
`define DRC_STATIC_ASSERT(lbl_, cond_, msg_) \
  if (!(cond_)) begin : lbl_ \
    $error(msg_); \
  end

package dist_ram_dp_clr_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } drc_state_e;

  // Smallest r with 2**r >= v.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

`endif

// File: rtl/dist_ram_dp_clr_seq.sv
// Clear sequencer: walks every address once after reset or a clear request.
module dist_ram_clr_seq
  import dist_ram_dp_clr_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  output logic              busy_o,
  output logic [ADDR_W-1:0] swp_addr_o,
  output logic              swp_we_o
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  // Power-up state is idle so the time-zero array contents stay readable.
  drc_state_e        state_q = ST_IDLE;
  logic [ADDR_W-1:0] cnt_q   = '0;
  logic              busy_q  = 1'b0;

  // FSM: reset or an idle clear starts a sweep; the edge writing LAST ends it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_SWEEP;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clr_i) begin
            state_q <= ST_SWEEP;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_SWEEP: begin
          if (cnt_q == LAST) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          cnt_q <= cnt_q + 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The reset edge itself restarts the sweep and does not write.
  assign swp_we_o   = (state_q == ST_SWEEP) && !rst_i;
  assign swp_addr_o = cnt_q;
  assign busy_o     = busy_q;

endmodule

// File: rtl/dist_ram_dp_clr.sv
// Dual-port distributed RAM with optional output registers and a clear sweep.
module dist_ram_dp_clr
  import dist_ram_dp_clr_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 32,
  parameter int               ADDR_W   = 5,
  parameter int               OUT_REG  = 0,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic              WCLK,
  input  logic              RST,
  input  logic              WE,
  input  logic [ADDR_W-1:0] A,
  input  logic [WIDTH-1:0]  D,
  input  logic [ADDR_W-1:0] DPRA,
  input  logic              CLR,
  output logic [WIDTH-1:0]  SPO,
  output logic [WIDTH-1:0]  DPO,
  output logic              BUSY
);

  `DRC_STATIC_ASSERT(g_chk_aw, ADDR_W >= clog2(DEPTH), "ADDR_W too small for DEPTH")
  `DRC_STATIC_ASSERT(g_chk_w, WIDTH >= 1, "WIDTH must be at least 1")

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH] = '{default: INIT_VAL};
  logic [ADDR_W-1:0] swp_addr;
  logic              swp_we;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [WIDTH-1:0]  spo_raw;
  logic [WIDTH-1:0]  dpo_raw;

  dist_ram_clr_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_seq (
    .clk_i      (WCLK),
    .rst_i      (RST),
    .clr_i      (CLR),
    .busy_o     (BUSY),
    .swp_addr_o (swp_addr),
    .swp_we_o   (swp_we)
  );

  // Write mux: the sweep owns the port while busy; user writes only when idle.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = A;
    wr_data = D;
    if (swp_we) begin
      wr_en   = 1'b1;
      wr_addr = swp_addr;
      wr_data = INIT_VAL;
    end else if (WE && !BUSY && !RST && ({1'b0, A} < DEPTH_C)) begin
      wr_en = 1'b1;
    end
  end

  // Storage array, single write port.
  always_ff @(posedge WCLK) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Asynchronous read of both ports; out-of-range addresses read as zero.
  always_comb begin
    spo_raw = ({1'b0, A} < DEPTH_C) ? mem_q[A] : '0;
    dpo_raw = ({1'b0, DPRA} < DEPTH_C) ? mem_q[DPRA] : '0;
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [WIDTH-1:0] spo_q = '0;
    logic [WIDTH-1:0] dpo_q = '0;
    // Registered reads sample the pre-edge array, giving read-first behaviour.
    always_ff @(posedge WCLK) begin
      if (RST) begin
        spo_q <= '0;
        dpo_q <= '0;
      end else begin
        spo_q <= spo_raw;
        dpo_q <= dpo_raw;
      end
    end
    assign SPO = spo_q;
    assign DPO = dpo_q;
  end else begin : g_comb
    assign SPO = spo_raw;
    assign DPO = dpo_raw;
  end

endmodule

// File: tb/tb_dist_ram_dp_clr.sv
// Bench: two instances (32 deep async read, 20 deep registered read) share
// stimulus and are checked against an array model of the RAM behaviour.
module tb_dist_ram_dp_clr;

  localparam logic [7:0] IV = 8'hA5;

  logic       clk = 1'b1;
  logic       rst = 1'b0, we = 1'b0, clr = 1'b0;
  logic [4:0] a = '0, dpra = '0;
  logic [7:0] d = '0;
  logic [7:0] spo0, dpo0, spo1, dpo1;
  logic       busy0, busy1;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dist_ram_dp_clr #(.WIDTH(8), .DEPTH(32), .ADDR_W(5), .OUT_REG(0), .INIT_VAL(IV)) u0 (
    .WCLK(clk), .RST(rst), .WE(we), .A(a), .D(d), .DPRA(dpra), .CLR(clr),
    .SPO(spo0), .DPO(dpo0), .BUSY(busy0));

  dist_ram_dp_clr #(.WIDTH(8), .DEPTH(20), .ADDR_W(5), .OUT_REG(1), .INIT_VAL(IV)) u1 (
    .WCLK(clk), .RST(rst), .WE(we), .A(a), .D(d), .DPRA(dpra), .CLR(clr),
    .SPO(spo1), .DPO(dpo1), .BUSY(busy1));

  // Reference model: index 0 is u0, index 1 is u1.
  logic [7:0] mm [2][32];
  bit         mb [2];
  int         mp [2];
  int         dep [2] = '{32, 20};
  logic [7:0] q_spo = '0, q_dpo = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] rd(input int k, input int adr);
    return (adr < dep[k]) ? mm[k][adr] : 8'h00;
  endfunction

  // One clock edge of the specified behaviour.
  task automatic model_edge();
    q_spo = rst ? 8'h00 : rd(1, int'(a));
    q_dpo = rst ? 8'h00 : rd(1, int'(dpra));
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mb[k] = 1'b1;
        mp[k] = 0;
      end else if (mb[k]) begin
        mm[k][mp[k]] = IV;
        mp[k]++;
        if (mp[k] == dep[k]) mb[k] = 1'b0;
      end else begin
        if (we && int'(a) < dep[k]) mm[k][a] = d;
        if (clr) begin
          mb[k] = 1'b1;
          mp[k] = 0;
        end
      end
    end
  endtask

  // Apply inputs after the falling edge, check old data, clock, check new data.
  task automatic step(input bit we_, input logic [4:0] a_, input logic [7:0] d_,
                      input logic [4:0] dpra_, input bit clr_, input bit rst_);
    @(negedge clk);
    we = we_; a = a_; d = d_; dpra = dpra_; clr = clr_; rst = rst_;
    #1;
    check("pre_spo0", spo0, rd(0, int'(a)));
    check("pre_dpo0", dpo0, rd(0, int'(dpra)));
    @(posedge clk);
    model_edge();
    #1;
    check("spo0", spo0, rd(0, int'(a)));
    check("dpo0", dpo0, rd(0, int'(dpra)));
    check("busy0", busy0, mb[0]);
    check("spo1", spo1, q_spo);
    check("dpo1", dpo1, q_dpo);
    check("busy1", busy1, mb[1]);
  endtask

  // Runs n idle steps (first one optionally with rst/clr) and counts BUSY samples.
  task automatic count_busy(input bit rst_, input bit clr_, input int n, input logic [4:0] rdad,
                            output int c0, output int c1);
    c0 = 0; c1 = 0;
    for (int i = 0; i < n; i++) begin
      step(1'b0, rdad, 8'h00, rdad, (i == 0) ? clr_ : 1'b0, (i == 0) ? rst_ : 1'b0);
      if (busy0) c0++;
      if (busy1) c1++;
    end
  endtask

  initial begin
    int c0, c1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) mm[k][i] = IV;
      mb[k] = 1'b0;
      mp[k] = 0;
    end

    // Power-up contents without any reset.
    #1;
    check("pwr_busy0", busy0, 1'b0);
    for (int i = 0; i < 32; i++) step(1'b0, 5'(i), 8'h00, 5'(31 - i), 1'b0, 1'b0);

    // Reset sweep; writes to address 3 attempted while u0 is busy.
    c0 = 0; c1 = 0;
    step(1'b0, 5'd3, 8'h11, 5'd3, 1'b0, 1'b1);
    if (busy0) c0++;
    if (busy1) c1++;
    for (int i = 0; i < 40; i++) begin
      step(busy0, 5'd3, 8'h11, 5'd3, 1'b0, 1'b0);
      if (busy0) c0++;
      if (busy1) c1++;
    end
    check("rst_busy_len0", c0, 32);
    check("rst_busy_len1", c1, 20);
    step(1'b0, 5'd3, 8'h00, 5'd3, 1'b0, 1'b0);
    check("we_during_busy", spo0, IV);

    // Idle write with read-back on DPRA.
    step(1'b1, 5'd5, 8'h3C, 5'd5, 1'b0, 1'b0);
    check("wr_dpo0", dpo0, 8'h3C);
    check("wr_dpo1_old", dpo1, IV);
    step(1'b0, 5'd5, 8'h00, 5'd5, 1'b0, 1'b0);
    check("wr_dpo1_new", dpo1, 8'h3C);

    // Out-of-range write/read on the 20-deep instance.
    step(1'b1, 5'd25, 8'h77, 5'd25, 1'b0, 1'b0);
    step(1'b0, 5'd25, 8'h00, 5'd25, 1'b0, 1'b0);
    check("oor_dpo1", dpo1, 8'h00);

    // Fill with index, clear, second clear mid-sweep is ignored.
    for (int i = 0; i < 32; i++) step(1'b1, 5'(i), 8'(i), 5'(i), 1'b0, 1'b0);
    c0 = 0; c1 = 0;
    for (int i = 0; i < 45; i++) begin
      step(1'b0, 5'd7, 8'h00, 5'd15, (i == 0) || (i == 10), 1'b0);
      if (busy0) c0++;
      if (busy1) c1++;
    end
    check("clr_busy_len0", c0, 32);
    check("clr_busy_len1", c1, 20);

    // Reset at sweep cycle 10 restarts the sweep.
    for (int i = 0; i < 32; i++) step(1'b1, 5'(i), 8'(i + 64), 5'(31 - i), 1'b0, 1'b0);
    step(1'b0, 5'd2, 8'h00, 5'd9, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 5'd2, 8'h00, 5'd9, 1'b0, 1'b0);
    @(negedge clk);
    we = 1'b0; a = 5'd2; dpra = 5'd9; clr = 1'b0; rst = 1'b1;
    @(posedge clk);
    model_edge();
    #1;
    check("rst_spo1_zero", spo1, 8'h00);
    check("rst_dpo1_zero", dpo1, 8'h00);
    check("rst_busy0", busy0, 1'b1);
    count_busy(1'b0, 1'b0, 40, 5'd4, c0, c1);
    check("rst_mid_len0", c0, 31);
    check("rst_mid_len1", c1, 19);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom), 8'($urandom), 5'($urandom),
           $urandom_range(0, 39) == 0, $urandom_range(0, 99) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
